// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants and types for the common data bus arbiter.
//   NUM_REQ / DATA_W / TAG_W : default sizing of the bus and its requesters
//   PTR_W                    : width of the round-robin pointer
//   REQ_*                    : requester index map (adders, mul/div, memory)
//   cdb_msg_t                : one broadcast beat {valid, tag, data}
package cdb_pkg;

  localparam int NUM_REQ = 7;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int PTR_W   = $clog2(NUM_REQ);

  // Requester slots on the bus.
  localparam int REQ_ADD1 = 0;
  localparam int REQ_ADD2 = 1;
  localparam int REQ_ADD3 = 2;
  localparam int REQ_MUL1 = 3;
  localparam int REQ_MUL2 = 4;
  localparam int REQ_MEM1 = 5;
  localparam int REQ_MEM2 = 6;

  // Tag 0 means "no producer"; a result carrying it is never broadcast.
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_msg_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// cdb_rr_pick: combinational round-robin picker.
//   req    : request vector, one bit per requester
//   rr_ptr : index where the search starts (ascending, wraps NUM_REQ-1 -> 0)
//   grant  : one-hot (or zero) selection
//   idx    : encoded index of the selected requester (0 when none)
//   any    : at least one request was selected
module cdb_rr_pick #(
  parameter int NUM_REQ = 7,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W:0] sum;
  logic [PTR_W-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Candidate index = (rr_ptr + k) mod NUM_REQ, one extra bit to hold the carry.
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      j = sum[PTR_W-1:0];
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter driving the common data bus.
//   clk, reset            : clock, asynchronous active-high reset
//   flush                 : squash; no grant this cycle, bus idle next cycle
//   req_valid/data/tag    : per-requester pending result
//   req_ready             : one-hot-or-zero grant (combinational)
//   cdb_valid/data/tag    : registered broadcast
//   tag_err               : registered pulse, a zero-tag result was consumed
//
// Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
// it holds valid/data/tag stable until then. req_ready never depends on a
// transfer completing, and nothing is stored for a requester that drops valid.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = cdb_pkg::NUM_REQ,
  parameter int DATA_W  = cdb_pkg::DATA_W,
  parameter int TAG_W   = cdb_pkg::TAG_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_W-1:0]              cdb_data,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic                           cdb_valid,
  output logic                           tag_err
);

  localparam int RR_W = $clog2(NUM_REQ);

  logic [RR_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] req_eligible;
  logic [NUM_REQ-1:0] grant;
  logic [RR_W-1:0]    grant_idx;
  logic               grant_any;

  cdb_msg_t cdb_q;
  cdb_msg_t cdb_d;
  logic     tag_err_q;
  logic     tag_err_d;
  logic [TAG_W-1:0] win_tag;

  // Flush and reset both mask every request so no grant can leak out.
  assign req_eligible = (flush || reset) ? '0 : req_valid;

  cdb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (RR_W)
  ) u_pick (
    .req    (req_eligible),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .idx    (grant_idx),
    .any    (grant_any)
  );

  assign req_ready = grant;
  assign win_tag   = req_tag[grant_idx];

  always_comb begin
    cdb_d     = '0;
    tag_err_d = 1'b0;
    if (grant_any) begin
      if (win_tag == TAG_NONE) begin
        // Consumed but not broadcast: nobody waits on tag 0.
        tag_err_d = 1'b1;
      end else begin
        cdb_d.valid = 1'b1;
        cdb_d.tag   = win_tag;
        cdb_d.data  = req_data[grant_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_q     <= '0;
      tag_err_q <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      cdb_q     <= cdb_d;
      tag_err_q <= tag_err_d;
      if (grant_any) begin
        rr_ptr <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
      end
    end
  end

  assign cdb_valid = cdb_q.valid;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_data  = cdb_q.data;
  assign tag_err   = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int N  = 7;
  localparam int DW = 32;
  localparam int TW = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0][TW-1:0] req_tag;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     cdb_data;
  logic [TW-1:0]     cdb_tag;
  logic              cdb_valid;
  logic              tag_err;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_valid (cdb_valid),
    .tag_err   (tag_err)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, ".valid"}, 64'(cdb_valid), 64'd0);
    check({name, ".tag"},   64'(cdb_tag),   64'd0);
    check({name, ".data"},  64'(cdb_data),  64'd0);
    check({name, ".err"},   64'(tag_err),   64'd0);
  endtask

  task automatic check_bcast(input string name, input logic [TW-1:0] t, input logic [DW-1:0] d);
    check({name, ".valid"}, 64'(cdb_valid), 64'd1);
    check({name, ".tag"},   64'(cdb_tag),   64'(t));
    check({name, ".data"},  64'(cdb_data),  64'(d));
    check({name, ".err"},   64'(tag_err),   64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_tag   = '0;

    // Reset state, and no grant while reset is held.
    #3;
    check_idle("reset");
    check("reset.rr_ptr", 64'(dut.rr_ptr), 64'd0);
    req_valid = 7'b1111111;
    #1;
    check("reset.ready", 64'(req_ready), 64'd0);
    tick();
    req_valid = '0;
    #2 reset = 1'b0;

    // Single requester 0, tag 3, data 0x11.
    req_valid   = 7'b0000001;
    req_tag[0]  = 4'd3;
    req_data[0] = 32'h11;
    #1;
    check("single.ready", 64'(req_ready), 64'h01);
    tick();
    req_valid = '0;
    check_bcast("single", 4'd3, 32'h11);
    check("single.rr_ptr", 64'(dut.rr_ptr), 64'd1);
    tick();
    check_idle("single.after");

    // Mid-stream reset pulse so the all-valid run starts at index 0.
    reset = 1'b1;
    #2 reset = 1'b0;

    // All seven valid: strict rotation, one broadcast every cycle.
    for (int i = 0; i < N; i++) begin
      req_tag[i]  = TW'(i + 1);
      req_data[i] = 32'h100 + 32'(i);
    end
    req_valid = 7'b1111111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr%0d.ready", c), 64'(req_ready), 64'(7'b1 << (c % N)));
      tick();
      check_bcast($sformatf("rr%0d", c), TW'((c % N) + 1), 32'h100 + 32'(c % N));
    end
    req_valid = '0;
    check("rr.rr_ptr", 64'(dut.rr_ptr), 64'd1);
    tick();
    check_idle("rr.after");

    // Move rr_ptr to 6 via requester 5.
    req_valid = 7'b0100000;
    #1;
    check("wrap.pre.ready", 64'(req_ready), 64'h20);
    tick();
    req_valid = '0;
    check("wrap.rr_ptr6", 64'(dut.rr_ptr), 64'd6);

    // Requesters 2 and 5 with rr_ptr=6: wrap to 2, then 5.
    req_valid = 7'b0100100;
    #1;
    check("wrap.first", 64'(req_ready), 64'h04);
    tick();
    req_valid = 7'b0100000;
    check_bcast("wrap.b2", 4'd3, 32'h102);
    #1;
    check("wrap.second", 64'(req_ready), 64'h20);
    tick();
    req_valid = '0;
    check_bcast("wrap.b5", 4'd6, 32'h105);
    check("wrap.rr_ptr", 64'(dut.rr_ptr), 64'd6);

    // Flush beats requester 4; pointer stays; grant follows once flush drops.
    flush     = 1'b1;
    req_valid = 7'b0010000;
    #1;
    check("flush.ready", 64'(req_ready), 64'h00);
    tick();
    check_idle("flush");
    check("flush.rr_ptr", 64'(dut.rr_ptr), 64'd6);
    flush = 1'b0;
    #1;
    check("flush.release", 64'(req_ready), 64'h10);
    tick();
    req_valid = '0;
    check_bcast("flush.b4", 4'd5, 32'h104);
    check("flush.rr_ptr5", 64'(dut.rr_ptr), 64'd5);

    // Zero tag on requester 1: consumed, error pulse, no broadcast.
    req_tag[1]  = 4'd0;
    req_data[1] = 32'hAB;
    req_valid   = 7'b0000010;
    #1;
    check("zero.ready", 64'(req_ready), 64'h02);
    tick();
    req_valid = '0;
    check("zero.err",   64'(tag_err),   64'd1);
    check("zero.valid", 64'(cdb_valid), 64'd0);
    check("zero.tag",   64'(cdb_tag),   64'd0);
    check("zero.data",  64'(cdb_data),  64'd0);
    check("zero.rr_ptr", 64'(dut.rr_ptr), 64'd2);
    tick();
    check_idle("zero.after");

    // Asynchronous reset while a broadcast is on the bus.
    req_tag[3]  = 4'd9;
    req_data[3] = 32'hDEADBEEF;
    req_valid   = 7'b0001000;
    tick();
    req_tag[3]  = 4'd10;
    req_data[3] = 32'h0BADF00D;
    req_valid   = 7'b1001000;
    check_bcast("arst.before", 4'd9, 32'hDEADBEEF);
    #2 reset = 1'b1;
    #1;
    check_idle("arst.now");
    check("arst.rr_ptr", 64'(dut.rr_ptr), 64'd0);
    check("arst.ready",  64'(req_ready),  64'd0);
    tick();
    #2 reset = 1'b0;
    #1;
    check("arst.release", 64'(req_ready), 64'h08);
    tick();
    req_valid = 7'b1000000;
    check_bcast("arst.b3", 4'd10, 32'h0BADF00D);
    #1;
    check("arst.next", 64'(req_ready), 64'h40);
    tick();
    req_valid = '0;
    check_bcast("arst.b6", 4'd7, 32'h106);
    tick();
    check_idle("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, 7, number of result requesters (3 adders, 2 mul/div, 2 memory ports), index 0 = adder1 ... 6 = mem2.
REQ-002 Parameter DATA_W, 32, broadcast data width.
REQ-003 Parameter TAG_W, 4, reservation-station tag width; tag 0 = "no producer".
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  squash: no grant this cycle, CDB output forced idle next cycle.
REQ-007 req_valid  input  NUM_REQ  per-requester result-pending flag.
REQ-008 req_data  input  NUM_REQ x DATA_W  per-requester result value.
REQ-009 req_tag  input  NUM_REQ x TAG_W  per-requester producing tag.
REQ-010 req_ready  output  NUM_REQ  one-hot-or-zero grant, combinational from current inputs and state.
REQ-011 cdb_data  output  DATA_W  registered broadcast value.
REQ-012 cdb_tag  output  TAG_W  registered broadcast tag.
REQ-013 cdb_valid  output  1  registered broadcast strobe, one cycle per accepted result.
REQ-014 tag_err  output  1  registered one-cycle pulse: a zero-tag request was consumed.

Function
REQ-015 Transfer on requester i SHALL occur in a cycle with req_valid[i] && req_ready[i]; requester holds valid/data/tag stable until transfer.
REQ-016 At most one req_ready bit SHALL be high per cycle; none when flush=1 or no req_valid bit set.
REQ-017 Grant selection: round-robin, search starts at rr_ptr, ascending index with wrap from NUM_REQ-1 to 0; first valid index wins.
REQ-018 After a transfer on i, rr_ptr SHALL become (i+1) mod NUM_REQ; without a transfer rr_ptr unchanged.
REQ-019 Transfer on i with nonzero tag: next cycle cdb_valid=1, cdb_data=req_data[i], cdb_tag=req_tag[i], tag_err=0.
REQ-020 Transfer on i with tag 0: result consumed, next cycle cdb_valid=0, cdb_data=0, cdb_tag=0, tag_err=1.
REQ-021 No transfer (idle or flush): next cycle cdb_valid=0, cdb_data=0, cdb_tag=0, tag_err=0.
REQ-022 Back-to-back grants SHALL be supported: one broadcast per cycle sustained, no mandatory idle cycle between broadcasts.
REQ-023 Latency: request-to-broadcast 1 cycle when granted; worst-case wait for a continuously valid requester NUM_REQ-1 cycles.
REQ-024 Flush has priority over all requests; rr_ptr unchanged during flush.
REQ-025 Requester dropping req_valid without transfer is a protocol violation; the arbiter SHALL not store it.

Reset
REQ-026 Reset asserted (any time, incl. mid-stream): cdb_valid=0, cdb_data=0, cdb_tag=0, tag_err=0, rr_ptr=0 immediately.
REQ-027 While reset is high req_ready SHALL be all zero.
REQ-028 First cycle after reset release, grant search starts at index 0.

Structure
REQ-029 Package cdb_pkg holds NUM_REQ, DATA_W, TAG_W, requester index constants and cdb_msg_t {valid, tag, data}.
REQ-030 Sub-module cdb_rr_pick: combinational round-robin one-hot picker (inputs req vector, rr_ptr; outputs one-hot grant, encoded index, any).
REQ-031 rr_ptr width SHALL be $clog2(NUM_REQ); output registers and rr_ptr in cdb_arbiter.

Verification
REQ-032 Reset, then req_valid=7'b0000001, tag=3, data=0x11 -> ready[0] same cycle; next cycle cdb_valid=1, tag=3, data=0x11; rr_ptr=1.
REQ-033 All 7 valid continuously, tags 1..7 -> grants 0,1,2,3,4,5,6,0 on consecutive cycles; cdb_valid high every cycle after the first.
REQ-034 rr_ptr=6 with requesters 2 and 5 valid -> grant 2 (wrap), then 5; rr_ptr ends 6.
REQ-035 flush=1 with requester 4 valid -> req_ready=0, next cycle cdb_valid=0; flush drops -> requester 4 granted.
REQ-036 Requester 1 valid with tag 0, data 0xAB -> ready[1]; next cycle tag_err=1, cdb_valid=0.
REQ-037 Reset asserted asynchronously while cdb_valid=1 -> outputs zero before next edge; post-release grant from index 0.
